// File: rtl/add_round_key_stage_if.sv
// Handshake bundle between MIX_COLUMNS, the AddRoundKey stage and its consumer.
// The slave modport is the stage's view; the master modport is the surrounding datapath's view.
`timescale 1ns/1ps
interface add_round_key_stage_if #(
    parameter int DATA_W = 128
);
    logic              inValid;
    logic              inReady;
    logic [DATA_W-1:0] inData;
    logic [3:0]        inRound;
    logic              outValid;
    logic              outReady;
    logic [DATA_W-1:0] outData;
    logic [3:0]        outRound;
    logic              outLast;

    modport slave (
        input  inValid, inData, inRound, outReady,
        output inReady, outValid, outData, outRound, outLast
    );

    modport master (
        output inValid, inData, inRound, outReady,
        input  inReady, outValid, outData, outRound, outLast
    );
endinterface

// File: rtl/add_round_key_stage.sv
// AES-128 AddRoundKey stage: XORs each accepted state with its round key and
// queues the result in a 2-entry skid buffer whose head register drives the outputs.
`timescale 1ns/1ps
module add_round_key_stage #(
    parameter int NUM_KEYS = 11,
    parameter int DATA_W   = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_keyWrEn,
    input  logic [3:0]           i_keyWrAddr,
    input  logic [DATA_W-1:0]    i_keyWrData,
    add_round_key_stage_if.slave io_bus,
    output logic                 o_errRound
);

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skidState_t;

    logic [DATA_W-1:0] r_keys [NUM_KEYS];
    skidState_t        r_state;
    logic [DATA_W-1:0] r_headData;
    logic [3:0]        r_headRound;
    logic              r_headLast;
    logic [DATA_W-1:0] r_skidData;
    logic [3:0]        r_skidRound;
    logic              r_skidLast;
    logic              r_errRound;

    logic              w_push;
    logic              w_pop;
    logic              w_roundOk;
    logic [DATA_W-1:0] w_key;
    logic [DATA_W-1:0] w_result;
    logic              w_last;

    assign w_push    = io_bus.inValid & io_bus.inReady;
    assign w_pop     = io_bus.outValid & io_bus.outReady;
    assign w_roundOk = io_bus.inRound < 4'(NUM_KEYS);
    // The key store is read before this edge's write lands, so a same-cycle write still yields the old key.
    assign w_key     = w_roundOk ? r_keys[io_bus.inRound] : '0;
    assign w_result  = io_bus.inData ^ w_key;
    assign w_last    = io_bus.inRound == 4'(NUM_KEYS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_keys[i] <= '0;
            end
        end else if (i_keyWrEn && (i_keyWrAddr < 4'(NUM_KEYS))) begin
            r_keys[i_keyWrAddr] <= i_keyWrData;
        end
    end

    // The head register is the output; the skid register only fills when the head is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SKID_EMPTY;
            r_headData  <= '0;
            r_headRound <= '0;
            r_headLast  <= 1'b0;
            r_skidData  <= '0;
            r_skidRound <= '0;
            r_skidLast  <= 1'b0;
        end else begin
            case (r_state)
                SKID_EMPTY: begin
                    if (w_push) begin
                        r_headData  <= w_result;
                        r_headRound <= io_bus.inRound;
                        r_headLast  <= w_last;
                        r_state     <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (w_push && w_pop) begin
                        r_headData  <= w_result;
                        r_headRound <= io_bus.inRound;
                        r_headLast  <= w_last;
                    end else if (w_push) begin
                        r_skidData  <= w_result;
                        r_skidRound <= io_bus.inRound;
                        r_skidLast  <= w_last;
                        r_state     <= SKID_FULL;
                    end else if (w_pop) begin
                        r_state     <= SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (w_pop) begin
                        r_headData  <= r_skidData;
                        r_headRound <= r_skidRound;
                        r_headLast  <= r_skidLast;
                        r_state     <= SKID_ONE;
                    end
                end
                default: r_state <= SKID_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errRound <= 1'b0;
        end else if (w_push && !w_roundOk) begin
            r_errRound <= 1'b1;
        end
    end

    assign io_bus.inReady  = (r_state != SKID_FULL);
    assign io_bus.outValid = (r_state != SKID_EMPTY);
    assign io_bus.outData  = r_headData;
    assign io_bus.outRound = r_headRound;
    assign io_bus.outLast  = r_headLast;
    assign o_errRound      = r_errRound;

endmodule
